// File: rtl/hart_mem_arbiter.sv
// Arbitrates one single-ported synchronous-read memory between instruction fetch and data access.
// Optional grant/conflict statistics counters are enabled with `define HART_MEM_ARB_STATS_EN.
module hart_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int MEM_BYTES  = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_rdata
`ifdef HART_MEM_ARB_STATS_EN
    ,
    output logic [31:0] o_stat_if_grants,
    output logic [31:0] o_stat_d_grants,
    output logic [31:0] o_stat_conflicts
`endif
);

    localparam logic [3:0]  STARVE_MAX_C = 4'(STARVE_MAX);
    localparam logic [31:0] MEM_BYTES_C  = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr < MEM_BYTES_C);
    endfunction

    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_nxt_s;
    owner_e     rsp_owner_r;
    owner_e     rsp_owner_nxt_s;
    logic       rsp_err_r;
    logic       rsp_err_nxt_s;
    logic       if_gnt_s;
    logic       d_gnt_s;
    logic       if_ok_s;
    logic       d_ok_s;

    assign if_ok_s = addr_in_range(i_if_addr);
    assign d_ok_s  = addr_in_range(i_d_addr);

    // Grant selection: data has priority until fetch has lost STARVE_MAX times in a row.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (i_rst) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (i_if_req && i_d_req) begin
            if (starve_cnt_r == STARVE_MAX_C) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (i_if_req) begin
            if_gnt_s = 1'b1;
        end else if (i_d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Memory command from the winner; out-of-range winners are granted but never strobe memory.
    always_comb begin
        o_mem_addr  = 32'h0000_0000;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = 32'h0000_0000;
        o_mem_mask  = 4'b0000;
        if (if_gnt_s) begin
            o_mem_addr = i_if_addr;
            o_mem_ren  = if_ok_s;
            o_mem_mask = 4'b1111;
        end else if (d_gnt_s) begin
            o_mem_addr  = i_d_addr;
            o_mem_ren   = !i_d_wen && d_ok_s;
            o_mem_wen   = i_d_wen && d_ok_s;
            o_mem_wdata = i_d_wdata;
            o_mem_mask  = i_d_mask;
        end else begin
            o_mem_addr = 32'h0000_0000;
        end
    end

    // Next-state for the starvation counter and the read-response tracker.
    always_comb begin
        starve_cnt_nxt_s = 4'd0;
        rsp_owner_nxt_s  = OWN_NONE;
        rsp_err_nxt_s    = 1'b0;
        if (i_if_req && !if_gnt_s) begin
            if (starve_cnt_r >= STARVE_MAX_C) begin
                starve_cnt_nxt_s = STARVE_MAX_C;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_nxt_s = 4'd0;
        end
        if (if_gnt_s) begin
            rsp_owner_nxt_s = OWN_IF;
            rsp_err_nxt_s   = !if_ok_s;
        end else if (d_gnt_s && !i_d_wen) begin
            rsp_owner_nxt_s = OWN_D;
            rsp_err_nxt_s   = !d_ok_s;
        end else begin
            rsp_owner_nxt_s = OWN_NONE;
            rsp_err_nxt_s   = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_r <= 4'd0;
            rsp_owner_r  <= OWN_NONE;
            rsp_err_r    <= 1'b0;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
            rsp_owner_r  <= rsp_owner_nxt_s;
            rsp_err_r    <= rsp_err_nxt_s;
        end
    end

    // Responses are suppressed while reset is high so a read in flight at reset is dropped.
    always_comb begin
        o_if_rvalid = 1'b0;
        o_if_err    = 1'b0;
        o_if_rdata  = 32'h0000_0000;
        o_d_rvalid  = 1'b0;
        o_d_err     = 1'b0;
        o_d_rdata   = 32'h0000_0000;
        if (!i_rst) begin
            case (rsp_owner_r)
                OWN_IF: begin
                    o_if_rvalid = 1'b1;
                    o_if_err    = rsp_err_r;
                    o_if_rdata  = rsp_err_r ? 32'h0000_0000 : i_mem_rdata;
                end
                OWN_D: begin
                    o_d_rvalid = 1'b1;
                    o_d_err    = rsp_err_r;
                    o_d_rdata  = rsp_err_r ? 32'h0000_0000 : i_mem_rdata;
                end
                default: begin
                    o_if_rvalid = 1'b0;
                    o_d_rvalid  = 1'b0;
                end
            endcase
            if (d_gnt_s && i_d_wen && !d_ok_s) begin
                o_d_err = 1'b1;
            end else begin
                o_d_err = o_d_err;
            end
        end else begin
            o_if_rvalid = 1'b0;
            o_d_rvalid  = 1'b0;
        end
    end

    assign o_if_gnt = if_gnt_s;
    assign o_d_gnt  = d_gnt_s;

`ifdef HART_MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants_r;
    logic [31:0] stat_d_grants_r;
    logic [31:0] stat_conflicts_r;

    // Wrapping event counters; conflicts count both-requesting cycles regardless of outcome.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_if_grants_r <= 32'd0;
            stat_d_grants_r  <= 32'd0;
            stat_conflicts_r <= 32'd0;
        end else begin
            stat_if_grants_r <= stat_if_grants_r + {31'd0, if_gnt_s};
            stat_d_grants_r  <= stat_d_grants_r + {31'd0, d_gnt_s};
            stat_conflicts_r <= stat_conflicts_r + {31'd0, (i_if_req && i_d_req)};
        end
    end

    assign o_stat_if_grants = stat_if_grants_r;
    assign o_stat_d_grants  = stat_d_grants_r;
    assign o_stat_conflicts = stat_conflicts_r;
`endif

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed, table-driven bench for hart_mem_arbiter with a behavioural synchronous-read memory.
module tb_hart_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_wen;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ren, mem_wen;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
`ifdef HART_MEM_ARB_STATS_EN
    logic [31:0] stat_if, stat_d, stat_cf;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    hart_mem_arbiter #(.STARVE_MAX(4), .MEM_BYTES(4096)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .o_if_err    (if_err),
        .i_d_req     (d_req),
        .i_d_wen     (d_wen),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .i_d_mask    (d_mask),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_d_err     (d_err),
        .o_mem_addr  (mem_addr),
        .o_mem_ren   (mem_ren),
        .o_mem_wen   (mem_wen),
        .o_mem_wdata (mem_wdata),
        .o_mem_mask  (mem_mask),
        .i_mem_rdata (mem_rdata)
`ifdef HART_MEM_ARB_STATS_EN
        ,
        .o_stat_if_grants (stat_if),
        .o_stat_d_grants  (stat_d),
        .o_stat_conflicts (stat_cf)
`endif
    );

    // Memory model: byte-masked write, registered read that holds its value when not strobed.
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= mem[mem_addr[11:2]];
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dm;
        logic [1:0]  e_gnt;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        logic        e_ifv;
        logic        e_ife;
        logic [31:0] e_ifd;
        logic        e_dv;
        logic        e_de;
        logic [31:0] e_dd;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_wen   = dw;
        d_addr  = da;
        d_wdata = dwd;
        d_mask  = dm;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
        mem[0]    = 32'h0050_0093;
        mem[1]    = 32'h1111_1111;
        mem[2]    = 32'h2222_2222;
        mem[1023] = 32'h89AB_CDEF;
        mem_rdata = 32'h0000_0000;

        vecs[0]  = '{1'b1, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b10, 1'b1, 1'b0, 32'h0,    32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b10, 1'b1, 1'b0, 32'h4,    32'h0,        4'hF, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h8,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b10, 1'b1, 1'b0, 32'h8,    32'h0,        4'hF, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h10,   32'hDEAD_BEEF, 4'h3, 2'b01, 1'b0, 1'b1, 32'h10,   32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h10,   32'h0,        4'hF, 2'b01, 1'b1, 1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_BEEF};
        vecs[7]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h1000, 32'h0,        4'hF, 2'b01, 1'b0, 1'b0, 32'h1000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 32'h1,        4'hF, 2'b01, 1'b0, 1'b0, 32'h2000, 32'h1,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h14,   32'hCAFE_F00D, 4'h0, 2'b01, 1'b0, 1'b1, 32'h14,   32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h0,    1'b1, 1'b0, 32'h8,    32'h0,        4'hF, 2'b01, 1'b1, 1'b0, 32'h8,    32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h2222_2222};
        vecs[14] = '{1'b1, 32'h1004, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b10, 1'b0, 1'b0, 32'h1004, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 32'hFFC,  1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b10, 1'b1, 1'b0, 32'hFFC,  32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 32'h89AB_CDEF, 1'b0, 1'b0, 32'h0};

        // Initial reset and idle state.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_idle", {8'h0, if_gnt, d_gnt, mem_ren, mem_wen, if_rvalid, if_err, d_rvalid, d_err,
                             if_rdata, d_rdata}, 80'h0);
`ifdef HART_MEM_ARB_STATS_EN
        check("stats_reset", {16'h0, stat_if, stat_d[15:0], stat_cf[15:0]}, 80'h0);
`endif

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd, vecs[i].dm);
            #1;
            check($sformatf("cmd[%0d]", i),
                  {6'h0, if_gnt, d_gnt, mem_ren, mem_wen, mem_addr, mem_wdata, mem_mask},
                  {6'h0, vecs[i].e_gnt, vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_mask});
            check($sformatf("rsp[%0d]", i),
                  {12'h0, if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata},
                  {12'h0, vecs[i].e_ifv, vecs[i].e_ife, vecs[i].e_ifd, vecs[i].e_dv, vecs[i].e_de, vecs[i].e_dd});
        end

        // Reset in the cycle after a fetch grant drops that response.
        @(negedge clk);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 check("rstA_fetch_gnt", {78'h0, if_gnt, d_gnt}, {78'h0, 2'b10});
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        #1 check("rstA_during", {72'h0, if_gnt, d_gnt, mem_ren, mem_wen, if_rvalid, if_err, d_rvalid, d_err}, 80'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 check("rstA_after", {78'h0, if_rvalid, d_rvalid}, 80'h0);

        // Continuous conflict: period-5 pattern with fetch winning every fifth cycle.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
            #1 check($sformatf("starve[%0d]", c), {78'h0, if_gnt, d_gnt},
                     {78'h0, ((c % 5) == 4) ? 2'b10 : 2'b01});
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
`ifdef HART_MEM_ARB_STATS_EN
        check("stats_conflicts", {48'h0, stat_cf}, {48'h0, 32'd10});
        check("stats_d_grants",  {48'h0, stat_d},  {48'h0, 32'd8});
        check("stats_if_grants", {48'h0, stat_if}, {48'h0, 32'd2});
`endif

        // Reset clears a saturated starvation count: first post-reset conflict goes to data.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
            #1 check($sformatf("rstB_pre[%0d]", c), {78'h0, if_gnt, d_gnt}, {78'h0, 2'b01});
        end
        @(negedge clk);
        rst = 1'b1;
        #1 check("rstB_during", {76'h0, if_gnt, d_gnt, mem_ren, d_rvalid}, 80'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rstB_first_conflict", {77'h0, if_gnt, d_gnt, d_rvalid}, {77'h0, 3'b010});
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 check("rstB_load_rsp", {47'h0, d_rvalid, d_rdata}, {47'h0, 1'b1, 32'h1111_1111});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
